// File: rtl/bf16_div_seq.sv
// bf16_div_seq: iterative bfloat16 divider, c = a / b.
// Restoring division producing one quotient bit per clock, with a start/ready
// handshake and a one-cycle out_valid pulse per result.
// Subnormal inputs are flushed to zero, and subnormal results flush to signed zero.
// Every NaN result returns CANON_NAN.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   start     request, accepted only while ready=1
//   a, b      bf16 dividend / divisor, sampled on the accepting edge
//   ready     idle, can accept start
//   out_valid one-cycle pulse: c holds a new result
//   c         bf16 quotient, held until the next result
//   busy      inverse of ready
module bf16_div_seq #(
  parameter int unsigned QBITS     = 10,
  parameter logic [15:0] CANON_NAN = 16'h7FC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        out_valid,
  output logic [15:0] c,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, UNPACK, DIV, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]       a_r, b_r;
  logic [9:0]        rem;
  logic [7:0]        mb;
  logic [QBITS-1:0]  q;
  logic [3:0]        cnt;
  logic signed [9:0] exp_r;
  logic              sign_r;
  logic [15:0]       res;

  // Operand classification on the latched operands
  logic [7:0]        ea, eb;
  logic [7:0]        ma, mbv;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              sign_u;
  logic              spec_hit;
  logic [15:0]       spec_val;
  logic signed [9:0] exp_u;

  always_comb begin
    ea     = a_r[14:7];
    eb     = b_r[14:7];
    ma     = {1'b1, a_r[6:0]};
    mbv    = {1'b1, b_r[6:0]};
    sign_u = a_r[15] ^ b_r[15];
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (a_r[6:0] == 7'h00);
    b_inf  = (eb == 8'hFF) && (b_r[6:0] == 7'h00);
    a_nan  = (ea == 8'hFF) && (a_r[6:0] != 7'h00);
    b_nan  = (eb == 8'hFF) && (b_r[6:0] != 7'h00);
    exp_u  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    spec_hit = 1'b1;
    spec_val = 16'h0000;
    if (a_nan || b_nan)
      spec_val = CANON_NAN;
    else if ((a_inf && b_inf) || (a_zero && b_zero))
      spec_val = CANON_NAN;
    else if (a_inf || b_zero)
      spec_val = {sign_u, 8'hFF, 7'h00};
    else if (a_zero || b_inf)
      spec_val = {sign_u, 15'h0000};
    else
      spec_hit = 1'b0;
  end

  // Round to nearest even: q = {int bit, 7 fraction bits, guard, round}
  logic              rnd_up;
  logic [8:0]        mant_sum;
  logic signed [9:0] exp_f;
  logic [15:0]       rnd_val;

  always_comb begin
    rnd_up   = q[1] & (q[0] | (|rem) | q[2]);
    mant_sum = {1'b0, q[QBITS-1:2]} + {8'h00, rnd_up};
    exp_f    = exp_r + $signed({9'd0, mant_sum[8]});
    if (exp_f >= 10'sd255)
      rnd_val = {sign_r, 8'hFF, 7'h00};
    else if (exp_f <= 10'sd0)
      rnd_val = {sign_r, 15'h0000};
    else
      rnd_val = {sign_r, exp_f[7:0], mant_sum[8] ? 7'h00 : mant_sum[6:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = spec_hit ? DONE : DIV;
      DIV:     if (cnt == 4'(QBITS - 1)) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      rem       <= '0;
      mb        <= '0;
      q         <= '0;
      cnt       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
      res       <= '0;
      c         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
          end
        end
        UNPACK: begin
          sign_r <= sign_u;
          cnt    <= '0;
          q      <= '0;
          mb     <= mbv;
          res    <= spec_val;
          // Pre-shift a smaller dividend so the quotient lands in [1,2)
          if (ma < mbv) begin
            rem   <= {1'b0, ma, 1'b0};
            exp_r <= exp_u - 10'sd1;
          end else begin
            rem   <= {2'b00, ma};
            exp_r <= exp_u;
          end
        end
        DIV: begin
          if (rem >= {2'b00, mb}) begin
            rem <= {rem[8:0] - {1'b0, mb}, 1'b0};
            q   <= {q[QBITS-2:0], 1'b1};
          end else begin
            rem <= {rem[8:0], 1'b0};
            q   <= {q[QBITS-2:0], 1'b0};
          end
          cnt <= cnt + 4'd1;
        end
        ROUND: res <= rnd_val;
        DONE: begin
          c         <= res;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_bf16_div_seq.sv
// Directed and randomised checks for bf16_div_seq.
module tb_bf16_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        ready;
  logic        out_valid;
  logic [15:0] c;
  logic        busy;

  int tests = 0;
  int fails = 0;

  bf16_div_seq #(.QBITS(10), .CANON_NAN(16'h7FC0)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .out_valid(out_valid), .c(c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Exact integer long division with round-to-nearest-even to bf16
  function automatic logic [15:0] ref_div(input logic [15:0] x, input logic [15:0] y);
    int          e;
    int unsigned mx, my, num, qq, rr, m, rest, half;
    logic [7:0]  ef;
    logic [7:0]  mf;
    mx   = {24'd0, 1'b1, x[6:0]};
    my   = {24'd0, 1'b1, y[6:0]};
    num  = mx << 16;
    qq   = num / my;
    rr   = num % my;
    e    = int'(x[14:7]) - int'(y[14:7]) + 127;
    if (qq >= 32'h10000) begin
      m = qq >> 9; rest = qq & 32'h1FF; half = 32'h100;
    end else begin
      m = qq >> 8; rest = qq & 32'hFF;  half = 32'h80;
      e = e - 1;
    end
    if (rest > half || (rest == half && (rr != 0 || (m % 2) == 1))) m = m + 1;
    if (m == 256) begin m = 128; e = e + 1; end
    ef = e[7:0];
    mf = m[7:0];
    if (e >= 255)     return {x[15] ^ y[15], 8'hFF, 7'h00};
    else if (e <= 0)  return {x[15] ^ y[15], 15'h0000};
    else              return {x[15] ^ y[15], ef, mf[6:0]};
  endfunction

  // Issues one request and waits (bounded) for its result
  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] res, output int lat,
                        output int busy_cycles, output bit timeout);
    int g;
    res = '0; lat = 0; busy_cycles = 0; timeout = 1'b1; g = 0;
    @(negedge clk);
    while (!ready && g < 50) begin @(negedge clk); g++; end
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (lat < 40) begin
      if (!ready) busy_cycles++;
      @(posedge clk); #1;
      lat++;
      if (out_valid) begin res = c; timeout = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    tests++; if (c !== 16'h0000) begin fails++; $display("FAIL reset_c got=%h exp=0000", c); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [15:0] r; int lat, bc; bit to;
    run_op(16'h3F80, 16'h3F80, r, lat, bc, to);
    tests++; if (to || r !== 16'h3F80) begin fails++; $display("FAIL one_by_one got=%h exp=3F80 timeout=%0d", r, to); end
    tests++; if (lat != 13) begin fails++; $display("FAIL one_by_one_latency got=%0d exp=13", lat); end
    tests++; if (bc != 13) begin fails++; $display("FAIL busy_cycles got=%0d exp=13", bc); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL valid_single_cycle got=%b exp=0", out_valid); end
    tests++; if (c !== 16'h3F80) begin fails++; $display("FAIL c_held got=%h exp=3F80", c); end
  endtask

  task automatic test_normal;
    logic [15:0] va [6] = '{16'h4040, 16'hC000, 16'h3F80, 16'h7F00, 16'h0080, 16'hBF80};
    logic [15:0] vb [6] = '{16'h4000, 16'h3F00, 16'h4040, 16'h0080, 16'h7F00, 16'h4040};
    logic [15:0] ve [6] = '{16'h3FC0, 16'hC080, 16'h3EAB, 16'h7F80, 16'h0000, 16'hBEAB};
    logic [15:0] r; int lat, bc; bit to;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], r, lat, bc, to);
      tests++; if (to || r !== ve[i]) begin fails++; $display("FAIL normal_%0d %h/%h got=%h exp=%h", i, va[i], vb[i], r, ve[i]); end
      tests++; if (lat != 13) begin fails++; $display("FAIL normal_lat_%0d got=%0d exp=13", i, lat); end
    end
  endtask

  task automatic test_special;
    logic [15:0] va [8] = '{16'h3F80, 16'h0000, 16'h0000, 16'h7FC1, 16'h7F80, 16'hFF80, 16'hBF80, 16'h3F80};
    logic [15:0] vb [8] = '{16'h0000, 16'h0000, 16'h3F80, 16'h3F80, 16'h7F80, 16'h3F80, 16'h7F80, 16'h8000};
    logic [15:0] ve [8] = '{16'h7F80, 16'h7FC0, 16'h0000, 16'h7FC0, 16'h7FC0, 16'hFF80, 16'h8000, 16'hFF80};
    logic [15:0] r; int lat, bc; bit to;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], r, lat, bc, to);
      tests++; if (to || r !== ve[i]) begin fails++; $display("FAIL special_%0d %h/%h got=%h exp=%h", i, va[i], vb[i], r, ve[i]); end
      tests++; if (lat != 2) begin fails++; $display("FAIL special_lat_%0d got=%0d exp=2", i, lat); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] va [3] = '{16'h3F80, 16'h4040, 16'hC000};
    logic [15:0] vb [3] = '{16'h3F80, 16'h4000, 16'h3F00};
    logic [15:0] ve [3] = '{16'h3F80, 16'h3FC0, 16'hC080};
    int idx, got, edge_n, last;
    idx = 0; got = 0; edge_n = 0; last = 0;
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      @(negedge clk);
      if (ready && idx < 3) begin
        a = va[idx]; b = vb[idx]; start = 1'b1; idx++;
      end else if (ready) begin
        start = 1'b0;
      end else begin
        a = 16'($urandom); b = 16'($urandom);
      end
      @(posedge clk); #1;
      edge_n++;
      if (out_valid) begin
        tests++; if (c !== ve[got]) begin fails++; $display("FAIL b2b_%0d got=%h exp=%h", got, c, ve[got]); end
        if (got > 0) begin
          tests++; if (edge_n - last != 14) begin fails++; $display("FAIL b2b_period_%0d got=%0d exp=14", got, edge_n - last); end
        end
        last = edge_n;
        got++;
      end
    end
    start = 1'b0;
    tests++; if (got != 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", got); end
  endtask

  task automatic test_reset_mid_op;
    logic [15:0] r; int lat, bc, seen; bit to;
    run_op(16'h3F80, 16'h3F80, r, lat, bc, to);
    @(negedge clk);
    a = 16'h4040; b = 16'h4000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++; if (c !== 16'h0000) begin fails++; $display("FAIL midrst_c got=%h exp=0000", c); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL midrst_ready got=%b exp=1", ready); end
    tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midrst_valid_busy got=%b%b exp=00", out_valid, busy); end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    tests++; if (seen != 0) begin fails++; $display("FAIL midrst_no_valid got=%0d exp=0", seen); end
    run_op(16'h3F80, 16'h4040, r, lat, bc, to);
    tests++; if (to || r !== 16'h3EAB) begin fails++; $display("FAIL after_rst got=%h exp=3EAB", r); end
  endtask

  task automatic test_random;
    logic [15:0] x, y, r, e; int lat, bc; bit to;
    for (int i = 0; i < 1000; i++) begin
      x = {1'($urandom), 8'($urandom_range(254, 1)), 7'($urandom)};
      y = {1'($urandom), 8'($urandom_range(254, 1)), 7'($urandom)};
      e = ref_div(x, y);
      run_op(x, y, r, lat, bc, to);
      tests++; if (to || r !== e) begin fails++; $display("FAIL random_%0d %h/%h got=%h exp=%h", i, x, y, r, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_normal();
    test_special();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
